// File: rtl/ex_stage.sv
// Execute stage: forwarded operand select, combinational ALU with a 5-level
// right shifter, and a one-entry EX/MEM output register with valid/ready, stall and flush.
module ex_stage #(
    parameter int XLEN = 32,
    parameter int OP_W = 4
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            flush_i,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [OP_W-1:0] alu_op_i,
    input  logic [4:0]      rs1_addr_i,
    input  logic [4:0]      rs2_addr_i,
    input  logic [XLEN-1:0] rs1_data_i,
    input  logic [XLEN-1:0] rs2_data_i,
    input  logic [XLEN-1:0] imm_i,
    input  logic            use_imm_i,
    input  logic [4:0]      rd_addr_i,
    input  logic            rd_we_i,
    input  logic            wb_we_i,
    input  logic [4:0]      wb_rd_i,
    input  logic [XLEN-1:0] wb_data_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [XLEN-1:0] result_o,
    output logic [4:0]      rd_addr_o,
    output logic            rd_we_o,
    output logic [31:0]     stall_cnt_o
);

    localparam logic [OP_W-1:0] OP_ADD   = OP_W'(0);
    localparam logic [OP_W-1:0] OP_SUB   = OP_W'(1);
    localparam logic [OP_W-1:0] OP_SLL   = OP_W'(2);
    localparam logic [OP_W-1:0] OP_SRL   = OP_W'(3);
    localparam logic [OP_W-1:0] OP_SRA   = OP_W'(4);
    localparam logic [OP_W-1:0] OP_AND   = OP_W'(5);
    localparam logic [OP_W-1:0] OP_OR    = OP_W'(6);
    localparam logic [OP_W-1:0] OP_XOR   = OP_W'(7);
    localparam logic [OP_W-1:0] OP_SLT   = OP_W'(8);
    localparam logic [OP_W-1:0] OP_SLTU  = OP_W'(9);
    localparam logic [OP_W-1:0] OP_PASSB = OP_W'(10);

    logic            r_valid;
    logic [XLEN-1:0] r_result;
    logic [4:0]      r_rd;
    logic            r_we;
    logic [31:0]     r_stall;

    logic            w_in_ready;
    logic [XLEN-1:0] w_fwd_rs1;
    logic [XLEN-1:0] w_fwd_rs2;
    logic [XLEN-1:0] w_op_a;
    logic [XLEN-1:0] w_op_b;
    logic [4:0]      w_sh;
    logic [XLEN-1:0] w_alu;

    // Shared shifter: conditional stages of 1/2/4/8/16, fill bit selects SRL vs SRA.
    function automatic logic [XLEN-1:0] shift_right(input logic [XLEN-1:0] a,
                                                    input logic [4:0] sh,
                                                    input logic fill);
        logic [XLEN-1:0] s;
        s = a;
        if (sh[0]) s = {fill, s[XLEN-1:1]};
        if (sh[1]) s = {{2{fill}}, s[XLEN-1:2]};
        if (sh[2]) s = {{4{fill}}, s[XLEN-1:4]};
        if (sh[3]) s = {{8{fill}}, s[XLEN-1:8]};
        if (sh[4]) s = {{16{fill}}, s[XLEN-1:16]};
        return s;
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] c);
        return (c == 32'hFFFF_FFFF) ? c : c + 32'd1;
    endfunction

    assign w_in_ready = !r_valid || out_ready_i;

    always_comb begin
        w_fwd_rs1 = rs1_data_i;
        if (r_valid && r_we && (r_rd != 5'd0) && (r_rd == rs1_addr_i))
            w_fwd_rs1 = r_result;
        else if (wb_we_i && (wb_rd_i != 5'd0) && (wb_rd_i == rs1_addr_i))
            w_fwd_rs1 = wb_data_i;

        w_fwd_rs2 = rs2_data_i;
        if (r_valid && r_we && (r_rd != 5'd0) && (r_rd == rs2_addr_i))
            w_fwd_rs2 = r_result;
        else if (wb_we_i && (wb_rd_i != 5'd0) && (wb_rd_i == rs2_addr_i))
            w_fwd_rs2 = wb_data_i;
    end

    assign w_op_a = w_fwd_rs1;
    assign w_op_b = use_imm_i ? imm_i : w_fwd_rs2;
    assign w_sh   = w_op_b[4:0];

    always_comb begin
        w_alu = '0;
        case (alu_op_i)
            OP_ADD:   w_alu = w_op_a + w_op_b;
            OP_SUB:   w_alu = w_op_a - w_op_b;
            OP_SLL:   w_alu = w_op_a << w_sh;
            OP_SRL:   w_alu = shift_right(w_op_a, w_sh, 1'b0);
            OP_SRA:   w_alu = shift_right(w_op_a, w_sh, w_op_a[XLEN-1]);
            OP_AND:   w_alu = w_op_a & w_op_b;
            OP_OR:    w_alu = w_op_a | w_op_b;
            OP_XOR:   w_alu = w_op_a ^ w_op_b;
            OP_SLT:   w_alu = {{(XLEN-1){1'b0}}, ($signed(w_op_a) < $signed(w_op_b))};
            OP_SLTU:  w_alu = {{(XLEN-1){1'b0}}, (w_op_a < w_op_b)};
            OP_PASSB: w_alu = w_op_b;
            default:  w_alu = '0;
        endcase
    end

    // EX/MEM register: flush beats accept, accept beats drain.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_valid  <= 1'b0;
            r_result <= '0;
            r_rd     <= 5'd0;
            r_we     <= 1'b0;
            r_stall  <= 32'd0;
        end else begin
            if (flush_i) begin
                r_valid <= 1'b0;
            end else if (in_valid_i && w_in_ready) begin
                r_valid  <= 1'b1;
                r_result <= w_alu;
                r_rd     <= rd_addr_i;
                r_we     <= rd_we_i;
            end else if (out_ready_i) begin
                r_valid <= 1'b0;
            end
            if (r_valid && !out_ready_i)
                r_stall <= sat_inc(r_stall);
        end
    end

    assign in_ready_o  = w_in_ready;
    assign out_valid_o = r_valid;
    assign result_o    = r_result;
    assign rd_addr_o   = r_rd;
    assign rd_we_o     = r_we;
    assign stall_cnt_o = r_stall;

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: shifts, ALU ops, forwarding priority,
// back-pressure, flush and asynchronous reset.
module tb_ex_stage;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        flush_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [3:0]  alu_op_i;
    logic [4:0]  rs1_addr_i;
    logic [4:0]  rs2_addr_i;
    logic [31:0] rs1_data_i;
    logic [31:0] rs2_data_i;
    logic [31:0] imm_i;
    logic        use_imm_i;
    logic [4:0]  rd_addr_i;
    logic        rd_we_i;
    logic        wb_we_i;
    logic [4:0]  wb_rd_i;
    logic [31:0] wb_data_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [31:0] result_o;
    logic [4:0]  rd_addr_o;
    logic        rd_we_o;
    logic [31:0] stall_cnt_o;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk_i = ~clk_i;

    ex_stage #(.XLEN(32), .OP_W(4)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .flush_i(flush_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .alu_op_i(alu_op_i),
        .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i),
        .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i),
        .imm_i(imm_i), .use_imm_i(use_imm_i),
        .rd_addr_i(rd_addr_i), .rd_we_i(rd_we_i),
        .wb_we_i(wb_we_i), .wb_rd_i(wb_rd_i), .wb_data_i(wb_data_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .result_o(result_o), .rd_addr_o(rd_addr_o), .rd_we_o(rd_we_o),
        .stall_cnt_o(stall_cnt_o)
    );

    task automatic set_idle();
        flush_i = 0; in_valid_i = 0; alu_op_i = 0;
        rs1_addr_i = 0; rs2_addr_i = 0; rs1_data_i = 0; rs2_data_i = 0;
        imm_i = 0; use_imm_i = 1; rd_addr_i = 0; rd_we_i = 0;
        wb_we_i = 0; wb_rd_i = 0; wb_data_i = 0; out_ready_i = 1;
    endtask

    // Immediate-form instruction with rs1 from the register file (index 1, nothing forwards it).
    task automatic drive_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        in_valid_i = 1; alu_op_i = op; rs1_addr_i = 5'd1; rs1_data_i = a;
        use_imm_i = 1; imm_i = b; rd_addr_i = 5'd0; rd_we_i = 0;
        wb_we_i = 0; out_ready_i = 1; flush_i = 0;
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        set_idle();
        rst_n_i = 0;
        #12;
        n_cmp++;
        if ({out_valid_o, result_o, rd_addr_o, rd_we_o, stall_cnt_o} !== 71'd0) begin
            n_bad++;
            $display("FAIL reset_outputs: got v=%b res=%h rd=%0d we=%b stall=%0d, want all zero",
                     out_valid_o, result_o, rd_addr_o, rd_we_o, stall_cnt_o);
        end
        n_cmp++;
        if (in_ready_o !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready_o);
        end
        @(negedge clk_i);
        rst_n_i = 1;
        tick();
    endtask

    task automatic test_shift();
        logic [3:0]  ops [0:6];
        logic [31:0] va  [0:6];
        logic [31:0] vb  [0:6];
        logic [31:0] ve  [0:6];
        ops = '{4'd3, 4'd4, 4'd3, 4'd4, 4'd3, 4'd4, 4'd2};
        va  = '{32'h8000_00F0, 32'h8000_00F0, 32'h8000_00F0, 32'h8000_00F0,
                32'h8000_00F0, 32'h8000_00F0, 32'h0000_0003};
        vb  = '{32'h0000_0024, 32'h0000_0024, 32'h0000_0000, 32'h0000_0000,
                32'h0000_001F, 32'h0000_001F, 32'hFFFF_FFE4};
        ve  = '{32'h0800_000F, 32'hF800_000F, 32'h8000_00F0, 32'h8000_00F0,
                32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0030};
        for (int i = 0; i < 7; i++) begin
            drive_op(ops[i], va[i], vb[i]);
            tick();
            n_cmp++;
            if (result_o !== ve[i] || out_valid_o !== 1'b1) begin
                n_bad++;
                $display("FAIL shift[%0d] op=%0d: got res=%h v=%b want res=%h v=1",
                         i, ops[i], result_o, out_valid_o, ve[i]);
            end
        end
        set_idle();
        tick();
    endtask

    task automatic test_alu_misc();
        logic [3:0]  ops [0:9];
        logic [31:0] va  [0:9];
        logic [31:0] vb  [0:9];
        logic [31:0] ve  [0:9];
        ops = '{4'd8, 4'd9, 4'd1, 4'd12, 4'd0, 4'd5, 4'd6, 4'd7, 4'd10, 4'd11};
        va  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h1234_5678, 32'h5,
                32'h0000_F0F0, 32'h0000_F0F0, 32'h0000_F0F0, 32'hDEAD_0000, 32'h7};
        vb  = '{32'h1, 32'h1, 32'h1, 32'h1, 32'h7,
                32'h0000_FF00, 32'h0000_FF00, 32'h0000_FF00, 32'hCAFE_BABE, 32'h9};
        ve  = '{32'h1, 32'h0, 32'hFFFF_FFFF, 32'h0, 32'hC,
                32'h0000_F000, 32'h0000_FFF0, 32'h0000_0FF0, 32'hCAFE_BABE, 32'h0};
        for (int i = 0; i < 10; i++) begin
            drive_op(ops[i], va[i], vb[i]);
            tick();
            n_cmp++;
            if (result_o !== ve[i]) begin
                n_bad++;
                $display("FAIL alu[%0d] op=%0d: got %h want %h", i, ops[i], result_o, ve[i]);
            end
        end
        set_idle();
        tick();
    endtask

    task automatic test_forward();
        // EX/MEM gets rd=5 <- 0x11
        drive_op(4'd10, 32'h0, 32'h11);
        rd_addr_i = 5'd5; rd_we_i = 1;
        tick();
        // ADD rs1=5 + imm 0 with both EX/MEM and WB matching
        drive_op(4'd0, 32'h33, 32'h0);
        rs1_addr_i = 5'd5; wb_we_i = 1; wb_rd_i = 5'd5; wb_data_i = 32'h22;
        rd_addr_i = 5'd6;
        tick();
        n_cmp++;
        if (result_o !== 32'h11) begin
            n_bad++;
            $display("FAIL fwd_exmem_priority: got %h want 00000011", result_o);
        end
        // drain so EX/MEM is invalid
        in_valid_i = 0;
        tick();
        in_valid_i = 1;
        tick();
        n_cmp++;
        if (result_o !== 32'h22) begin
            n_bad++;
            $display("FAIL fwd_wb: got %h want 00000022", result_o);
        end
        // EX/MEM now holds rd=0 writer, WB to rd=0, rs1=0
        drive_op(4'd10, 32'h0, 32'h44);
        rd_addr_i = 5'd0; rd_we_i = 1;
        tick();
        drive_op(4'd0, 32'h33, 32'h0);
        rs1_addr_i = 5'd0; wb_we_i = 1; wb_rd_i = 5'd0; wb_data_i = 32'h22;
        tick();
        n_cmp++;
        if (result_o !== 32'h33) begin
            n_bad++;
            $display("FAIL fwd_x0: got %h want 00000033", result_o);
        end
        // rs2 path through WB, operand B not immediate
        drive_op(4'd10, 32'h0, 32'h0);
        use_imm_i = 0; rs2_addr_i = 5'd7; rs2_data_i = 32'h66;
        wb_we_i = 1; wb_rd_i = 5'd7; wb_data_i = 32'h55;
        tick();
        n_cmp++;
        if (result_o !== 32'h55) begin
            n_bad++;
            $display("FAIL fwd_rs2_wb: got %h want 00000055", result_o);
        end
        set_idle();
        tick();
    endtask

    task automatic test_back_to_back();
        drive_op(4'd10, 32'h0, 32'hAB);
        rd_addr_i = 5'd3; rd_we_i = 1;
        tick();
        drive_op(4'd10, 32'h0, 32'hCD);
        rd_addr_i = 5'd4; rd_we_i = 1;
        out_ready_i = 0;
        #1;
        n_cmp++;
        if (in_ready_o !== 1'b0) begin
            n_bad++;
            $display("FAIL bp_in_ready: got %b want 0", in_ready_o);
        end
        tick(); tick(); tick();
        n_cmp++;
        if (out_valid_o !== 1'b1 || result_o !== 32'hAB || rd_addr_o !== 5'd3 || rd_we_o !== 1'b1) begin
            n_bad++;
            $display("FAIL bp_hold: got v=%b res=%h rd=%0d we=%b want v=1 res=000000ab rd=3 we=1",
                     out_valid_o, result_o, rd_addr_o, rd_we_o);
        end
        n_cmp++;
        if (stall_cnt_o !== 32'd3) begin
            n_bad++;
            $display("FAIL bp_stall_cnt: got %0d want 3", stall_cnt_o);
        end
        out_ready_i = 1;
        #1;
        n_cmp++;
        if (in_ready_o !== 1'b1) begin
            n_bad++;
            $display("FAIL bp_release_ready: got %b want 1", in_ready_o);
        end
        tick();
        n_cmp++;
        if (out_valid_o !== 1'b1 || result_o !== 32'hCD || rd_addr_o !== 5'd4) begin
            n_bad++;
            $display("FAIL bp_drain_accept: got v=%b res=%h rd=%0d want v=1 res=000000cd rd=4",
                     out_valid_o, result_o, rd_addr_o);
        end
    endtask

    task automatic test_flush();
        drive_op(4'd10, 32'h0, 32'hEE);
        rd_addr_i = 5'd9; rd_we_i = 1;
        out_ready_i = 0; flush_i = 1;
        tick();
        set_idle();
        out_ready_i = 0;
        n_cmp++;
        if (out_valid_o !== 1'b0 || result_o !== 32'hCD || rd_addr_o !== 5'd4) begin
            n_bad++;
            $display("FAIL flush: got v=%b res=%h rd=%0d want v=0 res=000000cd rd=4",
                     out_valid_o, result_o, rd_addr_o);
        end
        tick();
        n_cmp++;
        if (stall_cnt_o !== 32'd4) begin
            n_bad++;
            $display("FAIL flush_stall_cnt: got %0d want 4", stall_cnt_o);
        end
        out_ready_i = 1;
    endtask

    task automatic test_async_reset();
        drive_op(4'd10, 32'h0, 32'h77);
        rd_addr_i = 5'd2; rd_we_i = 1;
        tick();
        set_idle();
        out_ready_i = 0;
        #2;
        rst_n_i = 0;
        #1;
        n_cmp++;
        if ({out_valid_o, result_o, rd_addr_o, rd_we_o, stall_cnt_o} !== 71'd0) begin
            n_bad++;
            $display("FAIL async_reset: got v=%b res=%h rd=%0d we=%b stall=%0d, want all zero",
                     out_valid_o, result_o, rd_addr_o, rd_we_o, stall_cnt_o);
        end
        @(negedge clk_i);
        rst_n_i = 1;
        out_ready_i = 1;
        tick();
    endtask

    initial begin
        test_reset();
        test_shift();
        test_alu_misc();
        test_forward();
        test_back_to_back();
        test_flush();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
